mips_cpu: RTL and testbench
===========================

Name: mips_cpu

Overview:
- Single-cycle, 32-bit MIPS-subset integer core.
- Drives a word-aligned program counter to an external instruction source and receives the instruction word for that PC in the same cycle.
- Executes one instruction per enabled cycle and exports a retirement/writeback trace so an external checker can compare results against a golden model.
- Instruction word 32'hFFFF_FFFF is the end-of-program marker and halts the core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DMEM_WORDS, 64, depth in 32-bit words of the internal data memory (power of two).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- pcEn  in  1  execute enable; when 0 the core holds all architectural state.
- pc  out  32  address of the current instruction; always word aligned.
- inst  in  32  instruction word at address pc, valid in the same cycle.
- retire  out  1  pulses high for one cycle per executed instruction.
- wb_en  out  1  register write performed by the retiring instruction.
- wb_addr  out  5  destination register.
- wb_data  out  32  value written.
- mem_we  out  1  store performed by the retiring instruction.
- mem_addr  out  32  byte address of the load or store.
- mem_wdata  out  32  store data.
- halted  out  1  sticky end-of-program flag.

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc=RESET_PC; halted=0; all 32 registers cleared to 0.
  - All trace outputs (retire, wb_en, wb_addr, wb_data, mem_we, mem_addr, mem_wdata) are 0.
  - Data memory contents are not cleared.
  - Reset overrides pcEn and halted.
- Execute cycle (pcEn=1, halted=0, reset=1): decode inst combinationally; at the rising edge update register file, data memory and pc.
- Trace outputs are registered: they describe the instruction that retired at that edge, are valid for exactly one cycle, and are 0 otherwise.
- pcEn=0 or halted=1: pc, registers and memory hold; retire=0.
- Halt: inst==32'hFFFF_FFFF in an execute cycle sets halted=1, does not retire, and does not change pc. Only reset clears halted.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Arithmetic rules:
  - All arithmetic wraps modulo 2^32; no overflow traps.
  - slt and slti compare signed; sltu and sltiu compare unsigned.
  - Immediates are sign-extended except for andi, ori and xori, which zero-extend.
  - lui computes imm<<16.
- Register $0:
  - Reads always return 0.
  - Writes to $0 are discarded and report wb_en=0.
- Next PC:
  - Default is pc+4.
  - Taken branch: pc+4+(sext(imm)<<2).
  - j and jal: {pc_plus4[31:28], target, 2'b00}.
  - jal writes pc+4 to $31.
  - jr: rs & ~32'h3.
- Memory:
  - Word index is addr[log2(DMEM_WORDS)+1:2]; addresses wrap silently.
  - addr[1:0] is ignored.
  - lw returns the word as stored before any store in the same cycle.
- Register-file read-during-write: reads see the old value (single-cycle, no hazard).
- Unknown opcode or funct: treated as NOP. It retires with wb_en=0 and mem_we=0, and pc advances by 4.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - alu_op_e enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI);
  - HALT_INSTR constant 32'hFFFF_FFFF.
- One sub-module, mips_alu: combinational, taking (a, b, shamt, alu_op) and producing (y, zero).
- Decoder, register file and data memory live inline in mips_cpu.

Test Plan:
- Reset then arithmetic: assert reset low 2 cycles, pcEn=1. Run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2. Required:
  - pc steps 0, 4, 8;
  - trace wb (1,5), (2,32'hFFFF_FFFD), (3,2).
- Logic and shifts: ori $4,$0,0xF0F0; lui $5,0x1234; sll $6,$4,4; slt $7,$2,$1; sltu $8,$2,$1. Required:
  - wb $4=0x0000F0F0, $5=0x12340000, $6=0x000F0F00, $7=1, $8=0.
- Memory: sw $3,8($0) then lw $9,8($0). Required:
  - first retire has mem_we=1, mem_addr=8, mem_wdata=2;
  - next retire has wb $9=2.
- Control flow: bne $1,$0,+2 at pc=0x10 -> next pc=0x1C. beq not taken -> pc+4. jal 0x40 at pc=0x20 -> pc=0x100 and wb $31=0x24. jr $31 -> pc=0x24.
- $0 and stall: addi $0,$0,7 -> retire=1, wb_en=0. Deassert pcEn for 3 cycles -> pc held and retire=0.
- Halt and mid-run reset: inst=0xFFFFFFFF -> halted=1, pc frozen, no further retire. Assert reset while halted -> pc=0, halted=0, and $1 reads 0 afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings and ALU operation type for mips_cpu
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational integer ALU for mips_cpu
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  alu_op_e     alu_op_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  always_comb begin
    y_o = 32'h0;
    unique case (alu_op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_NOR:  y_o = ~(a_i | b_i);
      ALU_SLT:  y_o = {31'h0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {31'h0, a_i < b_i};
      ALU_SLL:  y_o = b_i << shamt_i;
      ALU_SRL:  y_o = b_i >> shamt_i;
      ALU_SRA:  y_o = $unsigned($signed(b_i) >>> shamt_i);
      ALU_LUI:  y_o = {b_i[15:0], 16'h0};
      default:  y_o = 32'h0;
    endcase
  end

  assign zero_o = (y_o == 32'h0);

endmodule

// File: rtl/mips_cpu.sv
// rtl/mips_cpu.sv - single-cycle MIPS-subset core with registered retirement trace
module mips_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcEn,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        retire,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        halted
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic        halted_q;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic        retire_q, wb_en_q, mem_we_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q, mem_addr_q, mem_wdata_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, rs_val, rt_val, pc_plus4;

  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign shamt    = inst[10:6];
  assign funct    = inst[5:0];
  assign imm      = inst[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0, imm};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : regs_q[rt];
  assign pc_plus4 = pc_q + 32'd4;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        alu_zero;

  mips_alu u_alu (
    .a_i      (rs_val),
    .b_i      (alu_b),
    .shamt_i  (shamt),
    .alu_op_i (alu_op),
    .y_o      (alu_y),
    .zero_o   (alu_zero)
  );

  logic        reg_we, is_load, is_store;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, load_data;
  logic [AW-1:0] dm_idx;

  assign dm_idx    = alu_y[AW+1:2];
  assign load_data = dmem_q[dm_idx];

  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rt_val;
    reg_we   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    wr_addr  = rd;
    wr_data  = alu_y;
    pc_d     = pc_plus4;
    unique case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            reg_we = 1'b0;
            pc_d   = rs_val & ~32'h3;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_b = imm_sext; reg_we = 1'b1; wr_addr = rt; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = imm_sext; reg_we = 1'b1; wr_addr = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = imm_sext; reg_we = 1'b1; wr_addr = rt; end
      OP_ANDI:  begin alu_op = ALU_AND;  alu_b = imm_zext; reg_we = 1'b1; wr_addr = rt; end
      OP_ORI:   begin alu_op = ALU_OR;   alu_b = imm_zext; reg_we = 1'b1; wr_addr = rt; end
      OP_XORI:  begin alu_op = ALU_XOR;  alu_b = imm_zext; reg_we = 1'b1; wr_addr = rt; end
      OP_LUI:   begin alu_op = ALU_LUI;  alu_b = imm_zext; reg_we = 1'b1; wr_addr = rt; end
      OP_LW: begin
        alu_b   = imm_sext;
        reg_we  = 1'b1;
        is_load = 1'b1;
        wr_addr = rt;
        wr_data = load_data;
      end
      OP_SW: begin alu_b = imm_sext; is_store = 1'b1; end
      OP_BEQ, OP_BNE: begin
        alu_op = ALU_SUB;
        if (alu_zero == (opcode == OP_BEQ))
          pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
      end
      OP_J:   pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
      OP_JAL: begin
        pc_d    = {pc_plus4[31:28], inst[25:0], 2'b00};
        reg_we  = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus4;
      end
      default: ;
    endcase
  end

  logic exec, halt_now, wr_en;
  assign exec     = pcEn && !halted_q && (inst != HALT_INSTR);
  assign halt_now = pcEn && !halted_q && (inst == HALT_INSTR);
  assign wr_en    = reg_we && (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      retire_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      retire_q    <= exec;
      wb_en_q     <= exec && wr_en;
      wb_addr_q   <= (exec && wr_en) ? wr_addr : 5'd0;
      wb_data_q   <= (exec && wr_en) ? wr_data : 32'h0;
      mem_we_q    <= exec && is_store;
      mem_addr_q  <= (exec && (is_load || is_store)) ? alu_y : 32'h0;
      mem_wdata_q <= (exec && is_store) ? rt_val : 32'h0;
      if (exec) begin
        pc_q <= pc_d;
        if (wr_en) regs_q[wr_addr] <= wr_data;
      end else if (halt_now) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Data memory survives reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (reset && exec && is_store) dmem_q[dm_idx] <= rt_val;
  end

  assign pc        = pc_q;
  assign halted    = halted_q;
  assign retire    = retire_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips_cpu.sv
// tb/tb_mips_cpu.sv - directed self-checking bench for mips_cpu
module tb_mips_cpu;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, pcEn;
  logic [31:0] inst;
  logic [31:0] pc, wb_data, mem_addr, mem_wdata;
  logic [4:0]  wb_addr;
  logic        retire, wb_en, mem_we, halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .pcEn      (pcEn),
    .pc        (pc),
    .inst      (inst),
    .retire    (retire),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Check pc, execute one instruction across one edge, then check the trace.
  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] exp_pc,
                      input logic exp_wb_en, input logic [4:0] exp_wa, input logic [31:0] exp_wd);
    check({tag, ".pc"}, pc, exp_pc);
    inst = instr;
    pcEn = 1'b1;
    @(posedge clk); #1;
    check({tag, ".retire"}, {31'h0, retire}, 32'd1);
    check({tag, ".wb_en"}, {31'h0, wb_en}, {31'h0, exp_wb_en});
    if (exp_wb_en) begin
      check({tag, ".wb_addr"}, {27'h0, wb_addr}, {27'h0, exp_wa});
      check({tag, ".wb_data"}, wb_data, exp_wd);
    end
  endtask

  initial begin
    reset = 1'b0;
    pcEn  = 1'b1;
    inst  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc", pc, 32'h0);
    check("rst.halted", {31'h0, halted}, 32'd0);
    check("rst.retire", {31'h0, retire}, 32'd0);
    check("rst.wb_en", {31'h0, wb_en}, 32'd0);
    check("rst.mem_we", {31'h0, mem_we}, 32'd0);
    reset = 1'b1;

    step("addi1", enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5),      32'h00, 1'b1, 5'd1, 32'd5);
    step("addi2", enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD),   32'h04, 1'b1, 5'd2, 32'hFFFF_FFFD);
    step("add3",  enc_r(FN_ADD, 5'd1, 5'd2, 5'd3, 5'd0),  32'h08, 1'b1, 5'd3, 32'd2);
    step("ori4",  enc_i(OP_ORI, 5'd0, 5'd4, 16'hF0F0),    32'h0C, 1'b1, 5'd4, 32'h0000_F0F0);
    step("lui5",  enc_i(OP_LUI, 5'd0, 5'd5, 16'h1234),    32'h10, 1'b1, 5'd5, 32'h1234_0000);
    step("sll6",  enc_r(FN_SLL, 5'd0, 5'd4, 5'd6, 5'd4),  32'h14, 1'b1, 5'd6, 32'h000F_0F00);
    step("slt7",  enc_r(FN_SLT, 5'd2, 5'd1, 5'd7, 5'd0),  32'h18, 1'b1, 5'd7, 32'd1);
    step("sltu8", enc_r(FN_SLTU, 5'd2, 5'd1, 5'd8, 5'd0), 32'h1C, 1'b1, 5'd8, 32'd0);

    step("sw",    enc_i(OP_SW, 5'd0, 5'd3, 16'd8),        32'h20, 1'b0, 5'd0, 32'h0);
    check("sw.mem_we", {31'h0, mem_we}, 32'd1);
    check("sw.mem_addr", mem_addr, 32'd8);
    check("sw.mem_wdata", mem_wdata, 32'd2);
    step("lw9",   enc_i(OP_LW, 5'd0, 5'd9, 16'd8),        32'h24, 1'b1, 5'd9, 32'd2);
    check("lw.mem_we", {31'h0, mem_we}, 32'd0);

    step("bne",   enc_i(OP_BNE, 5'd1, 5'd0, 16'd2),       32'h28, 1'b0, 5'd0, 32'h0);
    step("beq",   enc_i(OP_BEQ, 5'd1, 5'd0, 16'd5),       32'h34, 1'b0, 5'd0, 32'h0);
    step("jal",   enc_j(OP_JAL, 26'h40),                  32'h38, 1'b1, 5'd31, 32'h3C);
    step("jr",    enc_r(FN_JR, 5'd31, 5'd0, 5'd0, 5'd0),  32'h100, 1'b0, 5'd0, 32'h0);
    step("addi0", enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7),      32'h3C, 1'b0, 5'd0, 32'h0);
    step("sub10", enc_r(FN_SUB, 5'd1, 5'd2, 5'd10, 5'd0), 32'h40, 1'b1, 5'd10, 32'd8);
    step("sra11", enc_r(FN_SRA, 5'd0, 5'd2, 5'd11, 5'd1), 32'h44, 1'b1, 5'd11, 32'hFFFF_FFFE);
    step("nop",   32'hF800_0000,                          32'h48, 1'b0, 5'd0, 32'h0);

    inst = enc_i(OP_ADDI, 5'd1, 5'd1, 16'd1);
    pcEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall.pc", pc, 32'h4C);
      check("stall.retire", {31'h0, retire}, 32'd0);
    end
    step("add12", enc_r(FN_ADD, 5'd1, 5'd0, 5'd12, 5'd0), 32'h4C, 1'b1, 5'd12, 32'd5);

    inst = HALT_INSTR;
    @(posedge clk); #1;
    check("halt.halted", {31'h0, halted}, 32'd1);
    check("halt.retire", {31'h0, retire}, 32'd0);
    check("halt.pc", pc, 32'h50);
    inst = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd9);
    repeat (2) @(posedge clk);
    #1;
    check("halted.pc", pc, 32'h50);
    check("halted.retire", {31'h0, retire}, 32'd0);
    check("halted.sticky", {31'h0, halted}, 32'd1);

    reset = 1'b0;
    @(posedge clk); #1;
    check("rst2.pc", pc, 32'h0);
    check("rst2.halted", {31'h0, halted}, 32'd0);
    reset = 1'b1;
    step("r1clr", enc_r(FN_ADD, 5'd1, 5'd0, 5'd13, 5'd0), 32'h00, 1'b1, 5'd13, 32'd0);
    step("dmkeep", enc_i(OP_LW, 5'd0, 5'd14, 16'd8),      32'h04, 1'b1, 5'd14, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
